// File: rtl/junction_ctrl_pkg.sv
// Shared definitions for the junction controller: state codes, LED codes,
// head/walk output bundle and the state->lamp decode helper.
package junction_ctrl_pkg;

  typedef enum logic [3:0] {
    A_RY   = 4'd0,
    A_GRN  = 4'd1,
    A_YEL  = 4'd2,
    B_RY   = 4'd3,
    B_GRN  = 4'd4,
    B_YEL  = 4'd5,
    ALLRED = 4'd6,
    PED    = 4'd7,
    FLASH  = 4'd8
  } state_t;

  typedef enum logic {DIR_A = 1'b0, DIR_B = 1'b1} dir_t;

  // {R,Y,G} lamp codes shared with the per-head drivers
  localparam logic [2:0] LED_R   = 3'b100;
  localparam logic [2:0] LED_RY  = 3'b110;
  localparam logic [2:0] LED_G   = 3'b001;
  localparam logic [2:0] LED_Y   = 3'b010;
  localparam logic [2:0] LED_OFF = 3'b000;

  typedef struct packed {
    logic [2:0] a;
    logic [2:0] b;
    logic       walk;
  } heads_t;

  // Non-served head shows red in every normal state; walk lamp only in PED.
  function automatic heads_t decode(state_t s, logic flash);
    heads_t h;
    h = '{a: LED_R, b: LED_R, walk: 1'b0};
    case (s)
      A_RY:  h.a = LED_RY;
      A_GRN: h.a = LED_G;
      A_YEL: h.a = LED_Y;
      B_RY:  h.b = LED_RY;
      B_GRN: h.b = LED_G;
      B_YEL: h.b = LED_Y;
      PED:   h.walk = 1'b1;
      FLASH: begin
        h.a = flash ? LED_Y : LED_OFF;
        h.b = h.a;
      end
      default: ;
    endcase
    return h;
  endfunction

endpackage

// File: rtl/junction_ctrl_phase_timer.sv
// Phase timer: loads duration-1 on phase entry, counts down on ce, holds at 0.
// Ports: clk, rst_n (async low), ce, load, value -> count, zero.
module junction_ctrl_phase_timer #(
  parameter int               CNT_W   = 8,
  parameter logic [CNT_W-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ce,
  input  logic             load,
  input  logic [CNT_W-1:0] value,
  output logic [CNT_W-1:0] count,
  output logic             zero
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  count <= RST_VAL;
    else if (load)               count <= value;
    else if (ce && count != '0)  count <= count - 1'b1;
  end

  assign zero = (count == '0);

endmodule

// File: rtl/junction_ctrl.sv
// Two-approach junction controller (main road A, side road B, ped crossing).
// Rests on A green, serves B / pedestrian requests with all-red clearance,
// and offers a night flashing-yellow mode. Sequencing advances on ce only.
// Ports: clk, rst_n (async low), ce, req_b, ped_btn, night ->
//        led_a/led_b {R,Y,G}, ped_walk, timer (ticks left), phase (state code).
module junction_ctrl
  import junction_ctrl_pkg::*;
#(
  parameter int CNT_W    = 8,
  parameter int T_RY     = 2,
  parameter int T_GRN_A  = 6,
  parameter int T_GRN_B  = 5,
  parameter int T_YEL    = 3,
  parameter int T_ALLRED = 2,
  parameter int T_WALK   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ce,
  input  logic             req_b,
  input  logic             ped_btn,
  input  logic             night,
  output logic [2:0]       led_a,
  output logic [2:0]       led_b,
  output logic             ped_walk,
  output logic [CNT_W-1:0] timer,
  output logic [3:0]       phase
);

  state_t           state, state_n;
  dir_t             last_dir, last_n;
  logic             flash_ph, req_b_pend, ped_pend;
  logic             t_zero, expire, load, clr_b, clr_p;
  logic [CNT_W-1:0] load_val;
  heads_t           heads;

  junction_ctrl_phase_timer #(
    .CNT_W  (CNT_W),
    .RST_VAL(CNT_W'(T_ALLRED - 1))
  ) u_timer (
    .clk  (clk),
    .rst_n(rst_n),
    .ce   (ce),
    .load (load),
    .value(load_val),
    .count(timer),
    .zero (t_zero)
  );

  assign expire = ce && t_zero;

  always_comb begin
    state_n = state;
    last_n  = last_dir;
    if (expire) begin
      case (state)
        A_RY:  state_n = A_GRN;
        // A green rests at timer 0 until something asks for the junction
        A_GRN: if (req_b_pend || ped_pend || night) state_n = A_YEL;
        A_YEL: begin state_n = ALLRED; last_n = DIR_A; end
        B_RY:  state_n = B_GRN;
        B_GRN: state_n = B_YEL;
        B_YEL: begin state_n = ALLRED; last_n = DIR_B; end
        ALLRED: begin
          if (night)                               state_n = FLASH;
          else if (ped_pend)                       state_n = PED;
          else if (last_dir == DIR_A && req_b_pend) state_n = B_RY;
          else                                     state_n = A_RY;
        end
        PED:   state_n = ALLRED;
        // FLASH keeps its timer at 0, so expiry is simply every ce
        FLASH: if (!night) begin state_n = ALLRED; last_n = DIR_B; end
        default: state_n = ALLRED;
      endcase
    end
  end

  // No phase transitions to itself, so any change of state is an entry
  assign load = (state_n != state);

  always_comb begin
    load_val = '0;
    case (state_n)
      A_RY, B_RY:   load_val = CNT_W'(T_RY - 1);
      A_GRN:        load_val = CNT_W'(T_GRN_A - 1);
      B_GRN:        load_val = CNT_W'(T_GRN_B - 1);
      A_YEL, B_YEL: load_val = CNT_W'(T_YEL - 1);
      ALLRED:       load_val = CNT_W'(T_ALLRED - 1);
      PED:          load_val = CNT_W'(T_WALK - 1);
      default:      load_val = '0;
    endcase
  end

  // Request latches run every clk; clear beats a same-cycle set. Held clear
  // around FLASH so night mode does not leave stale service requests.
  assign clr_b = (state == FLASH) || (state_n == FLASH) ||
                 (state != B_GRN && state_n == B_GRN);
  assign clr_p = (state == FLASH) || (state_n == FLASH) ||
                 (state != PED && state_n == PED);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ALLRED;
      last_dir   <= DIR_B;
      flash_ph   <= 1'b0;
      req_b_pend <= 1'b0;
      ped_pend   <= 1'b0;
    end else begin
      state      <= state_n;
      last_dir   <= last_n;
      req_b_pend <= clr_b ? 1'b0 : (req_b_pend | req_b);
      ped_pend   <= clr_p ? 1'b0 : (ped_pend | ped_btn);
      // entering FLASH from ALLRED starts dark; first ce lights yellow
      if (state != FLASH) flash_ph <= 1'b0;
      else if (ce)        flash_ph <= ~flash_ph;
    end
  end

  assign heads    = decode(state, flash_ph);
  assign led_a    = heads.a;
  assign led_b    = heads.b;
  assign ped_walk = heads.walk;
  assign phase    = state;

endmodule

// File: tb/tb_junction_ctrl.sv
// Bench for junction_ctrl: directed scenarios plus randomized traffic,
// compared every clk against a phase/tick reference model.
module tb_junction_ctrl;
  import junction_ctrl_pkg::*;

  localparam int CNT_W = 8;

  logic clk = 1'b0, rst_n = 1'b0, ce = 1'b0;
  logic req_b = 1'b0, ped_btn = 1'b0, night = 1'b0;
  logic [2:0] led_a, led_b;
  logic ped_walk;
  logic [CNT_W-1:0] timer;
  logic [3:0] phase;

  always #5 clk = ~clk;

  junction_ctrl dut (
    .clk(clk), .rst_n(rst_n), .ce(ce), .req_b(req_b), .ped_btn(ped_btn),
    .night(night), .led_a(led_a), .led_b(led_b), .ped_walk(ped_walk),
    .timer(timer), .phase(phase)
  );

  int checks = 0, failures = 0, cyc = 0;

  // reference model: current phase, ticks left, direction last served, requests
  state_t m_st;
  int     m_rem, m_fcnt;
  bit     m_last_a, m_rbp, m_pp;

  function automatic int dur(state_t s);
    case (s)
      A_RY, B_RY:   return 2;
      A_GRN:        return 6;
      B_GRN:        return 5;
      A_YEL, B_YEL: return 3;
      ALLRED:       return 2;
      PED:          return 4;
      default:      return 1;
    endcase
  endfunction

  function automatic logic [2:0] exp_led(bit head_a);
    if (m_st == FLASH) return (m_fcnt % 2 == 1) ? 3'b010 : 3'b000;
    if (m_st == (head_a ? A_RY  : B_RY))  return 3'b110;
    if (m_st == (head_a ? A_GRN : B_GRN)) return 3'b001;
    if (m_st == (head_a ? A_YEL : B_YEL)) return 3'b010;
    return 3'b100;
  endfunction

  task automatic model_reset();
    m_st = ALLRED; m_rem = 1; m_last_a = 0; m_rbp = 0; m_pp = 0; m_fcnt = 0;
  endtask

  task automatic model_step(input bit c, input bit rb, input bit pb, input bit nt);
    state_t nx = m_st;
    bit nl = m_last_a;
    if (c && m_rem == 0) begin
      case (m_st)
        A_RY:   nx = A_GRN;
        A_GRN:  if (m_rbp || m_pp || nt) nx = A_YEL;
        A_YEL:  begin nx = ALLRED; nl = 1; end
        B_RY:   nx = B_GRN;
        B_GRN:  nx = B_YEL;
        B_YEL:  begin nx = ALLRED; nl = 0; end
        ALLRED: nx = nt ? FLASH : m_pp ? PED : (m_last_a && m_rbp) ? B_RY : A_RY;
        PED:    nx = ALLRED;
        FLASH:  if (!nt) begin nx = ALLRED; nl = 0; end
        default: ;
      endcase
    end
    if (m_st == FLASH || nx == FLASH || (nx == B_GRN && m_st != B_GRN)) m_rbp = 0;
    else if (rb) m_rbp = 1;
    if (m_st == FLASH || nx == FLASH || (nx == PED && m_st != PED)) m_pp = 0;
    else if (pb) m_pp = 1;
    if (m_st == FLASH && c) m_fcnt++;
    if (nx != FLASH) m_fcnt = 0;
    if (nx != m_st) m_rem = dur(nx) - 1;
    else if (c && m_rem > 0) m_rem--;
    m_st = nx; m_last_a = nl;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, expv, $time);
    end
  endtask

  task automatic check_outputs();
    chk("led_a", 16'(led_a), 16'(exp_led(1)));
    chk("led_b", 16'(led_b), 16'(exp_led(0)));
    chk("ped_walk", 16'(ped_walk), 16'(m_st == PED));
    chk("timer", 16'(timer), 16'(m_rem));
    chk("phase", 16'(phase), 16'(4'(m_st)));
    chk("two_green", 16'(led_a == 3'b001 && led_b == 3'b001), 16'd0);
    chk("walk_green", 16'(ped_walk && (led_a == 3'b001 || led_b == 3'b001)), 16'd0);
  endtask

  function automatic bit ce_pat();
    return (cyc % 4) == 0;
  endfunction

  // enter at a negedge: drive, clock, advance model, check at next negedge
  task automatic cyc1(input bit c, input bit rb, input bit pb, input bit nt);
    ce = c; req_b = rb; ped_btn = pb; night = nt;
    @(posedge clk);
    model_step(c, rb, pb, nt);
    cyc++;
    @(negedge clk);
    check_outputs();
  endtask

  task automatic run(input int n, input bit rb, input bit pb, input bit nt);
    for (int i = 0; i < n; i++) cyc1(ce_pat(), rb, pb, nt);
  endtask

  task automatic wait_phase(input state_t target, input bit rb, input bit pb,
                            input bit nt, input int maxc, input string tag);
    int n = 0;
    while (m_st != target && n < maxc) begin
      cyc1(ce_pat(), rb, pb, nt);
      n++;
    end
    chk(tag, 16'(phase), 16'(4'(target)));
  endtask

  initial begin
    bit nt, c;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_outputs();
    chk("rst_timer", 16'(timer), 16'd1);
    chk("rst_phase", 16'(phase), 16'(4'(ALLRED)));
    rst_n = 1'b1;

    // idle: ALLRED, A_RY, then rest on A green
    run(60, 0, 0, 0);
    chk("idle_a_grn", 16'(led_a), 16'(3'b001));
    chk("idle_b_red", 16'(led_b), 16'(3'b100));

    // single-clk B request early in A green
    run(3, 0, 0, 0);
    cyc1(ce_pat(), 1, 0, 0);
    wait_phase(B_GRN, 0, 0, 0, 200, "req_b_served");
    run(80, 0, 0, 0);

    // B and pedestrian in the same clk
    cyc1(ce_pat(), 1, 1, 0);
    wait_phase(PED, 0, 0, 0, 200, "ped_first");
    wait_phase(B_RY, 0, 0, 0, 100, "b_after_ped");
    run(80, 0, 0, 0);

    // night mode and back
    run(60, 0, 0, 1);
    chk("night_flash", 16'(phase), 16'(4'(FLASH)));
    run(60, 0, 0, 0);

    // freeze mid B green
    wait_phase(B_GRN, 1, 0, 0, 600, "reach_bgrn");
    run(5, 0, 0, 0);
    for (int i = 0; i < 50; i++) cyc1(0, 0, 0, 0);
    chk("freeze_bgrn", 16'(phase), 16'(4'(B_GRN)));

    // async reset mid PED
    wait_phase(PED, 0, 1, 0, 600, "reach_ped");
    run(5, 0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_led_a", 16'(led_a), 16'(3'b100));
    chk("arst_led_b", 16'(led_b), 16'(3'b100));
    chk("arst_walk", 16'(ped_walk), 16'd0);
    chk("arst_timer", 16'(timer), 16'd1);
    model_reset();
    @(negedge clk);
    check_outputs();
    rst_n = 1'b1;

    // button held through PED entry re-arms the request
    wait_phase(PED, 0, 1, 0, 600, "ped_held_entry");
    run(3, 0, 1, 0);
    wait_phase(ALLRED, 0, 0, 0, 100, "ped_exit");
    wait_phase(PED, 0, 0, 0, 40, "ped_second");

    // randomized traffic
    nt = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(299) == 0) nt = !nt;
      c = ce_pat() && ($urandom_range(9) != 0);
      cyc1(c, $urandom_range(24) == 0, $urandom_range(39) == 0, nt);
    end
    run(200, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
